// File: rtl/cordic_phase_pkg.sv
// cordic_phase_pkg: shared mode/state enums and quadrant codes for the phase generator.
package cordic_phase_pkg;
    typedef enum logic [1:0] {MODE_CONT, MODE_SINGLE, MODE_BURST, MODE_REV} mode_e;
    typedef enum logic {IDLE, RUN} state_e;
    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;
endpackage

// File: rtl/cordic_quad_encode.sv
// cordic_quad_encode: maps a raw angle to {quadrant, in-quadrant offset}; quadrant tops are inclusive.
module cordic_quad_encode
    import cordic_phase_pkg::*;
#(
    parameter int QW     = 16,
    parameter int PERIOD = 360,
    parameter int AW     = $clog2(PERIOD)
) (
    input  logic [AW-1:0]   a,
    output logic [QW+1:0]   phase
);
    localparam logic [AW-1:0] Q1 = AW'(PERIOD / 4);
    localparam logic [AW-1:0] Q2 = AW'(PERIOD / 2);
    localparam logic [AW-1:0] Q3 = AW'(3 * PERIOD / 4);
    logic [1:0]    q;
    logic [AW-1:0] base;
    logic [AW-1:0] off;
    always_comb begin
        q     = a <= Q1 ? QUAD_0 : a <= Q2 ? QUAD_1 : a <= Q3 ? QUAD_2 : QUAD_3;
        base  = q == QUAD_0 ? '0 : q == QUAD_1 ? Q1 : q == QUAD_2 ? Q2 : Q3;
        off   = a - base;
        phase = {q, QW'(off)};
    end
endmodule

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: modular angle sweep source emitting quadrant-encoded phase words on a valid/ready stream.
module cordic_phase_gen
    import cordic_phase_pkg::*;
#(
    parameter int QW     = 16,
    parameter int PERIOD = 360,
    parameter int AW     = $clog2(PERIOD),
    parameter int BW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] step,
    input  logic [AW-1:0] start_angle,
    input  logic [BW-1:0] burst_len,
    output logic [QW+1:0] phase,
    output logic [AW-1:0] angle,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output logic          err
);
    localparam logic [AW:0] P = (AW+1)'(PERIOD);
    state_e        state;
    mode_e         mode_r;
    logic [AW-1:0] step_r;
    logic [BW-1:0] cnt;
    logic [AW:0]   travel;
    logic [AW:0]   sum;
    logic [AW:0]   travel_sum;
    logic          fwd_wrap;
    logic          rev_wrap;
    logic          nxt_wrap;
    logic [AW-1:0] nxt;
    logic [AW-1:0] enc_in;
    logic [QW+1:0] enc_phase;
    logic          legal;
    logic          last;
    logic          hs;
    always_comb begin
        sum        = {1'b0, angle} + {1'b0, step_r};
        fwd_wrap   = sum >= P;
        rev_wrap   = angle < step_r;
        nxt_wrap   = mode_r == MODE_REV ? rev_wrap : fwd_wrap;
        nxt        = mode_r == MODE_REV
                     ? (rev_wrap ? AW'({1'b0, angle} + P - {1'b0, step_r}) : angle - step_r)
                     : (fwd_wrap ? AW'(sum - P) : AW'(sum));
        travel_sum = travel + {1'b0, step_r};
        last       = (mode_r == MODE_SINGLE && travel_sum >= P) || (mode_r == MODE_BURST && cnt == BW'(1));
        legal      = {1'b0, step} < P && {1'b0, start_angle} < P
                     && !(mode_e'(mode) == MODE_SINGLE && step == '0)
                     && !(mode_e'(mode) == MODE_BURST && burst_len == '0);
        hs         = out_valid && out_ready;
        enc_in     = state == IDLE ? start_angle : nxt;
    end
    cordic_quad_encode #(.QW(QW), .PERIOD(PERIOD), .AW(AW)) u_enc (
        .a     (enc_in),
        .phase (enc_phase)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_r    <= MODE_CONT;
            step_r    <= '0;
            cnt       <= '0;
            travel    <= '0;
            phase     <= '0;
            angle     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE) begin
                if (start && !stop) begin
                    if (legal) begin
                        state     <= RUN;
                        mode_r    <= mode_e'(mode);
                        step_r    <= step;
                        cnt       <= burst_len;
                        travel    <= '0;
                        angle     <= start_angle;
                        phase     <= enc_phase;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (stop || (hs && last)) begin
                // A handshake landing with stop is consumed, but stop suppresses done.
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= !stop;
            end else if (hs) begin
                angle  <= nxt;
                phase  <= enc_phase;
                wrap   <= nxt_wrap;
                travel <= travel_sum;
                cnt    <= cnt - BW'(1);
            end
        end
    end
endmodule
